// File: rtl/prefetch_control_utlb_pkg.sv
// Shared types and constants for the code-prefetch controller and its micro-TLB.
package prefetch_control_utlb_pkg;

    typedef enum logic {
        STATE_REQ    = 1'b0,
        STATE_ICACHE = 1'b1
    } state_t;

    localparam int PAGE_SHIFT = 12;
    localparam int PAGE_SIZE  = 4096;
    localparam int OFF_W      = 12;
    localparam int VPN_W      = 20;
    localparam int PPN_W      = 20;

    typedef struct packed {
        logic             valid;
        logic [VPN_W-1:0] vpn;
        logic             su;
        logic [PPN_W-1:0] ppn;
        logic             cd;
    } utlb_entry_t;

    // A read burst never crosses the end of the current 4 KB page.
    function automatic logic [4:0] clamp_len(input logic [OFF_W-1:0] off, input logic [4:0] len);
        logic [12:0] left;
        left = 13'(PAGE_SIZE) - {1'b0, off};
        return (left < {8'd0, len}) ? left[4:0] : len;
    endfunction

endpackage

// File: rtl/prefetch_control_utlb_if.sv
// TLB request/response and icache read buses seen by the prefetch controller.
interface prefetch_control_utlb_if;
    logic        tlbcoderequest_do;
    logic [31:0] tlbcoderequest_address;
    logic        tlbcoderequest_su;
    logic        tlbcode_do;
    logic [31:0] tlbcode_linear;
    logic [31:0] tlbcode_physical;
    logic        tlbcode_cache_disable;
    logic        icacheread_do;
    logic [31:0] icacheread_address;
    logic [4:0]  icacheread_length;
    logic        icacheread_cache_disable;

    modport master (
        output tlbcoderequest_do, tlbcoderequest_address, tlbcoderequest_su,
        input  tlbcode_do, tlbcode_linear, tlbcode_physical, tlbcode_cache_disable,
        output icacheread_do, icacheread_address, icacheread_length, icacheread_cache_disable
    );

    modport slave (
        input  tlbcoderequest_do, tlbcoderequest_address, tlbcoderequest_su,
        output tlbcode_do, tlbcode_linear, tlbcode_physical, tlbcode_cache_disable,
        input  icacheread_do, icacheread_address, icacheread_length, icacheread_cache_disable
    );
endinterface

// File: rtl/prefetch_control_utlb_array.sv
// Fully-associative code micro-TLB: parallel lookup, round-robin fill, global flush.
module prefetch_utlb_array
    import prefetch_control_utlb_pkg::*;
#(
    parameter int ENTRIES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [VPN_W-1:0] lookup_vpn,
    input  logic             lookup_su,
    output logic             hit,
    output logic [PPN_W-1:0] hit_ppn,
    output logic             hit_cd,
    input  logic             alloc,
    input  logic [VPN_W-1:0] alloc_vpn,
    input  logic             alloc_su,
    input  logic [PPN_W-1:0] alloc_ppn,
    input  logic             alloc_cd
);

    localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    utlb_entry_t          entries [ENTRIES];
    logic [ENTRIES-1:0]   match;
    logic [PW-1:0]        ptr;
    logic                 wr;

    // Flush wins over a same-cycle fill, so a stale translation never survives.
    assign wr = alloc && !flush;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        assign match[g] = entries[g].valid && entries[g].vpn == lookup_vpn &&
                          entries[g].su == lookup_su;

        always_ff @(posedge clk) begin
            if (!rst_n)
                entries[g] <= '0;
            else if (flush)
                entries[g].valid <= 1'b0;
            else if (wr && ptr == PW'(g))
                entries[g] <= '{valid: 1'b1, vpn: alloc_vpn, su: alloc_su,
                                ppn: alloc_ppn, cd: alloc_cd};
        end
    end

    always_comb begin
        hit     = |match;
        hit_ppn = '0;
        hit_cd  = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (match[i]) begin
                hit_ppn = entries[i].ppn;
                hit_cd  = entries[i].cd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            ptr <= '0;
        else if (wr)
            ptr <= (ptr == PW'(ENTRIES - 1)) ? '0 : ptr + PW'(1);
    end

endmodule

// File: rtl/prefetch_control_utlb.sv
// Code-prefetch controller with micro-TLB; page-clamped icache bursts.
// Optional hit/miss counters when PREFETCH_UTLB_STATS_EN is defined.
module prefetch_control_utlb
    import prefetch_control_utlb_pkg::*;
#(
    parameter int UTLB_ENTRIES   = 4,
    parameter int FIFO_W         = 5,
    parameter int REQ_THRESHOLD  = 3,
    parameter int READ_THRESHOLD = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pr_reset,
    input  logic                   utlb_flush,
    input  logic [31:0]            prefetch_address,
    input  logic [4:0]             prefetch_length,
    input  logic                   prefetch_su,
    input  logic [FIFO_W-1:0]      prefetchfifo_used,
    prefetch_control_utlb_if.master bus
`ifdef PREFETCH_UTLB_STATS_EN
    ,
    output logic [15:0]            utlb_hits,
    output logic [15:0]            utlb_misses
`endif
);

    localparam logic [FIFO_W:0] REQ_TH  = (FIFO_W + 1)'(REQ_THRESHOLD);
    localparam logic [FIFO_W:0] READ_TH = (FIFO_W + 1)'(READ_THRESHOLD);

    state_t           state, state_nxt;
    logic [31:0]      linear, physical;
    logic             cache_disable;

    logic             hit, hit_cd, hit_eff, go, page_cross;
    logic [PPN_W-1:0] hit_ppn;
    logic [4:0]       len_clamp;
    logic [OFF_W-1:0] off;
    logic             tlb_do, rd_do, rd_cd;
    logic [31:0]      rd_addr;
    logic             load_hit, load_fill, save_off, alloc;

    assign off        = prefetch_address[OFF_W-1:0];
    assign len_clamp  = clamp_len(off, prefetch_length);
    assign go         = !pr_reset && prefetch_length != 5'd0 && {1'b0, prefetchfifo_used} < REQ_TH;
    assign hit_eff    = hit && !utlb_flush;
    assign page_cross = prefetch_address[31:PAGE_SHIFT] != linear[31:PAGE_SHIFT];

    prefetch_utlb_array #(.ENTRIES(UTLB_ENTRIES)) u_utlb (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (utlb_flush),
        .lookup_vpn (prefetch_address[31:PAGE_SHIFT]),
        .lookup_su  (prefetch_su),
        .hit        (hit),
        .hit_ppn    (hit_ppn),
        .hit_cd     (hit_cd),
        .alloc      (alloc),
        .alloc_vpn  (bus.tlbcode_linear[31:PAGE_SHIFT]),
        .alloc_su   (prefetch_su),
        .alloc_ppn  (bus.tlbcode_physical[31:PAGE_SHIFT]),
        .alloc_cd   (bus.tlbcode_cache_disable)
    );

    always_comb begin
        state_nxt = state;
        tlb_do    = 1'b0;
        rd_do     = 1'b0;
        rd_addr   = '0;
        rd_cd     = 1'b0;
        load_hit  = 1'b0;
        load_fill = 1'b0;
        save_off  = 1'b0;
        alloc     = 1'b0;
        case (state)
            STATE_REQ: begin
                if (go) begin
                    if (hit_eff) begin
                        rd_do     = 1'b1;
                        rd_addr   = {hit_ppn, off};
                        rd_cd     = hit_cd;
                        load_hit  = 1'b1;
                        state_nxt = STATE_ICACHE;
                    end else begin
                        tlb_do = 1'b1;
                        if (bus.tlbcode_do) begin
                            rd_do     = 1'b1;
                            rd_addr   = bus.tlbcode_physical;
                            rd_cd     = bus.tlbcode_cache_disable;
                            load_fill = 1'b1;
                            alloc     = !utlb_flush;
                            state_nxt = STATE_ICACHE;
                        end
                    end
                end
            end
            STATE_ICACHE: begin
                if (pr_reset || utlb_flush || page_cross) begin
                    state_nxt = STATE_REQ;
                end else begin
                    rd_do    = {1'b0, prefetchfifo_used} < READ_TH;
                    rd_addr  = {physical[31:PAGE_SHIFT], off};
                    rd_cd    = cache_disable;
                    save_off = 1'b1;
                end
            end
            default: state_nxt = STATE_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= STATE_REQ;
            linear        <= '0;
            physical      <= '0;
            cache_disable <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_hit) begin
                linear        <= prefetch_address;
                physical      <= {hit_ppn, off};
                cache_disable <= hit_cd;
            end else if (load_fill) begin
                linear        <= bus.tlbcode_linear;
                physical      <= bus.tlbcode_physical;
                cache_disable <= bus.tlbcode_cache_disable;
            end else if (save_off) begin
                linear[OFF_W-1:0]   <= off;
                physical[OFF_W-1:0] <= off;
            end
        end
    end

    assign bus.tlbcoderequest_do        = tlb_do;
    assign bus.tlbcoderequest_address   = tlb_do ? prefetch_address : '0;
    assign bus.tlbcoderequest_su        = tlb_do & prefetch_su;
    assign bus.icacheread_do            = rd_do;
    assign bus.icacheread_address       = rd_do ? rd_addr : '0;
    assign bus.icacheread_length        = rd_do ? len_clamp : '0;
    assign bus.icacheread_cache_disable = rd_do & rd_cd;

`ifdef PREFETCH_UTLB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            utlb_hits   <= '0;
            utlb_misses <= '0;
        end else begin
            if (load_hit && utlb_hits != 16'hFFFF)
                utlb_hits <= utlb_hits + 16'd1;
            if (load_fill && utlb_misses != 16'hFFFF)
                utlb_misses <= utlb_misses + 16'd1;
        end
    end
`endif

endmodule
